// File: rtl/int_exec_issue_ctrl_pkg.sv
// Shared types for the integer execute issue control slice; IMUL_LATENCY sets the multiplier depth.
// No logic, no latency, no backpressure.
`ifndef IMUL_LATENCY
`define IMUL_LATENCY 5
`endif

package int_exec_issue_ctrl_pkg;

    localparam int EXEC_PRF_W = 6;
    localparam int EXEC_ROB_W = 5;

    typedef enum logic [1:0] {
        FU_ALU  = 2'd0,
        FU_BR   = 2'd1,
        FU_IMUL = 2'd2
    } fu_type_t;

    typedef struct packed {
        logic                  valid;
        logic                  has_rd;
        logic [EXEC_PRF_W-1:0] prd;
        logic [EXEC_ROB_W-1:0] rob;
    } exec_meta_t;

    // Bubbles carry all-zero metadata so downstream fields need no extra gating.
    function automatic exec_meta_t make_meta(input logic fire, input logic has_rd,
                                             input logic [EXEC_PRF_W-1:0] prd,
                                             input logic [EXEC_ROB_W-1:0] rob);
        exec_meta_t m;
        m = '0;
        if (fire) begin
            m.valid  = 1'b1;
            m.has_rd = has_rd;
            m.prd    = prd;
            m.rob    = rob;
        end
        return m;
    endfunction

endpackage

// File: rtl/int_exec_issue_ctrl_meta_pipe.sv
// exec_meta_pipe: fixed-depth metadata shift register with synchronous clear.
// Latency DEPTH cycles; no backpressure, advances every cycle.
module exec_meta_pipe
    import int_exec_issue_ctrl_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  exec_meta_t in_meta,
    output exec_meta_t out_meta
);

    exec_meta_t stage [DEPTH];

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= in_meta;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign out_meta = stage[DEPTH-1];

endmodule

// File: rtl/int_exec_issue_ctrl.sv
// Steers issued uops to ALU/BR/IMUL and owns the single integer writeback port; writeback at
// fire+1 (ALU/BR) or fire+IMUL_LAT, stalls ALU issue on slot conflict. INT_EXEC_PERF_EN adds perf counters.
module int_exec_issue_ctrl
    import int_exec_issue_ctrl_pkg::*;
#(
    parameter int PRF_W    = EXEC_PRF_W,
    parameter int ROB_W    = EXEC_ROB_W,
    parameter int IMUL_LAT = `IMUL_LATENCY
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  fu_type_t         issue_fu,
    input  logic [PRF_W-1:0] issue_prd,
    input  logic [ROB_W-1:0] issue_rob,
    input  logic             issue_has_rd,
    output logic             alu_fire,
    output logic             br_fire,
    output logic             imul_fire,
    input  logic [31:0]      alu_out,
    input  logic             br_out,
    input  logic [31:0]      imul_out,
    output logic             wb_valid,
    output logic [PRF_W-1:0] wb_prd,
    output logic [ROB_W-1:0] wb_rob,
    output logic [31:0]      wb_data,
    output logic             br_valid,
    output logic [ROB_W-1:0] br_rob,
    output logic             br_taken
`ifdef INT_EXEC_PERF_EN
    ,
    output logic [31:0]      perf_issue_cnt,
    output logic [31:0]      perf_wb_stall_cnt
`endif
);

    logic [IMUL_LAT-1:0] res;
    exec_meta_t          alu_s1, br_s1, imul_last, hold_meta;
    logic [31:0]         hold_data;
    logic                accept, defer_now;

    // An ALU completion colliding with an IMUL completion is parked in the hold register.
    assign defer_now = alu_s1.valid && imul_last.valid;

    always_comb begin
        issue_ready = !(issue_fu == FU_ALU &&
                        ((issue_has_rd && res[0]) || hold_meta.valid || defer_now));
    end

    assign accept    = issue_valid && issue_ready && !flush;
    assign alu_fire  = accept && (issue_fu == FU_ALU);
    assign br_fire   = accept && (issue_fu == FU_BR);
    assign imul_fire = accept && (issue_fu == FU_IMUL);

    exec_meta_pipe #(.DEPTH(1)) u_alu_pipe (
        .clock(clock), .reset(reset), .clear(flush),
        .in_meta(make_meta(alu_fire, issue_has_rd, issue_prd, issue_rob)),
        .out_meta(alu_s1)
    );

    exec_meta_pipe #(.DEPTH(1)) u_br_pipe (
        .clock(clock), .reset(reset), .clear(flush),
        .in_meta(make_meta(br_fire, 1'b0, '0, issue_rob)),
        .out_meta(br_s1)
    );

    exec_meta_pipe #(.DEPTH(IMUL_LAT)) u_imul_pipe (
        .clock(clock), .reset(reset), .clear(flush),
        .in_meta(make_meta(imul_fire, issue_has_rd, issue_prd, issue_rob)),
        .out_meta(imul_last)
    );

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            res <= '0;
        end else begin
            res <= {1'b0, res[IMUL_LAT-1:1]};
            if (imul_fire && issue_has_rd) res[IMUL_LAT-2] <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            hold_meta <= '0;
            hold_data <= '0;
        end else if (defer_now) begin
            hold_meta <= alu_s1;
            hold_data <= alu_s1.has_rd ? alu_out : 32'd0;
        end else if (!imul_last.valid) begin
            hold_meta <= '0;
        end
    end

    // IMUL owns its reserved slot; a parked ALU completion drains before the next ALU can issue.
    always_comb begin
        wb_valid = 1'b0;
        wb_prd   = '0;
        wb_rob   = '0;
        wb_data  = '0;
        if (!flush) begin
            if (imul_last.valid) begin
                wb_valid = 1'b1;
                wb_rob   = imul_last.rob;
                if (imul_last.has_rd) begin
                    wb_prd  = imul_last.prd;
                    wb_data = imul_out;
                end
            end else if (hold_meta.valid) begin
                wb_valid = 1'b1;
                wb_rob   = hold_meta.rob;
                wb_data  = hold_data;
                if (hold_meta.has_rd) wb_prd = hold_meta.prd;
            end else if (alu_s1.valid) begin
                wb_valid = 1'b1;
                wb_rob   = alu_s1.rob;
                if (alu_s1.has_rd) begin
                    wb_prd  = alu_s1.prd;
                    wb_data = alu_out;
                end
            end
        end
    end

    assign br_valid = !flush && br_s1.valid;
    assign br_rob   = br_valid ? br_s1.rob : '0;
    assign br_taken = br_valid && br_out;

`ifdef INT_EXEC_PERF_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_issue_cnt    <= '0;
            perf_wb_stall_cnt <= '0;
        end else begin
            if (accept && perf_issue_cnt != 32'hFFFF_FFFF)
                perf_issue_cnt <= perf_issue_cnt + 32'd1;
            if (issue_valid && !issue_ready && perf_wb_stall_cnt != 32'hFFFF_FFFF)
                perf_wb_stall_cnt <= perf_wb_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_int_exec_issue_ctrl.sv
// Table-driven bench for int_exec_issue_ctrl with a writeback/branch scoreboard.
module tb_int_exec_issue_ctrl;
    import int_exec_issue_ctrl_pkg::*;

    localparam int L = `IMUL_LATENCY;

    logic       clock = 1'b0;
    logic       reset, flush, issue_valid, issue_ready, issue_has_rd;
    fu_type_t   issue_fu;
    logic [5:0] issue_prd, wb_prd;
    logic [4:0] issue_rob, wb_rob, br_rob;
    logic       alu_fire, br_fire, imul_fire, br_out, wb_valid, br_valid, br_taken;
    logic [31:0] alu_out, imul_out, wb_data;
`ifdef INT_EXEC_PERF_EN
    logic [31:0] perf_issue_cnt, perf_wb_stall_cnt;
`endif

    int_exec_issue_ctrl dut (
        .clock(clock), .reset(reset), .flush(flush),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_fu(issue_fu),
        .issue_prd(issue_prd), .issue_rob(issue_rob), .issue_has_rd(issue_has_rd),
        .alu_fire(alu_fire), .br_fire(br_fire), .imul_fire(imul_fire),
        .alu_out(alu_out), .br_out(br_out), .imul_out(imul_out),
        .wb_valid(wb_valid), .wb_prd(wb_prd), .wb_rob(wb_rob), .wb_data(wb_data),
        .br_valid(br_valid), .br_rob(br_rob), .br_taken(br_taken)
`ifdef INT_EXEC_PERF_EN
        , .perf_issue_cnt(perf_issue_cnt), .perf_wb_stall_cnt(perf_wb_stall_cnt)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          vld;
        fu_type_t    fu;
        bit          rd;
        logic [5:0]  prd;
        logic [4:0]  rob;
        bit          fl;
        bit          rst;
        bit          rdy;
        logic [31:0] dat;
    } vec_t;

    typedef struct {
        int          cyc;
        logic [5:0]  prd;
        logic [4:0]  rob;
        logic [31:0] data;
    } wb_t;

    typedef struct {
        int         cyc;
        logic [4:0] rob;
        logic       taken;
    } br_t;

    vec_t        tv[$];
    wb_t         wb_q[$];
    br_t         br_q[$];
    logic [31:0] alu_at[int];
    logic [31:0] imul_at[int];
    logic        br_at[int];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic void add(bit vld, fu_type_t fu, bit rd, int prd, int rob,
                                bit fl, bit rst, bit rdy, logic [31:0] dat);
        vec_t v;
        v.vld = vld; v.fu = fu; v.rd = rd; v.prd = prd[5:0]; v.rob = rob[4:0];
        v.fl = fl; v.rst = rst; v.rdy = rdy; v.dat = dat;
        tv.push_back(v);
    endfunction

    function automatic void idle(int n, bit fl = 1'b0, bit rst = 1'b0);
        for (int i = 0; i < n; i++) add(0, FU_BR, 0, 0, 0, fl, rst, 1, 0);
    endfunction

    function automatic void push_wb(wb_t e);
        int j;
        j = 0;
        while (j < wb_q.size() && wb_q[j].cyc < e.cyc) j++;
        wb_q.insert(j, e);
    endfunction

    function automatic bit slot_taken(int c);
        foreach (wb_q[i]) if (wb_q[i].cyc == c) return 1'b1;
        return 1'b0;
    endfunction

    initial begin
        vec_t v;
        wb_t  e;
        br_t  b;
        bit   acc;
        logic [2:0] exp_fire;

        // Plain ALU op, prd=5 rob=3.
        add(1, FU_ALU, 1, 5, 3, 0, 0, 1, 32'h1234); idle(2);
        // Single IMUL, prd=7.
        add(1, FU_IMUL, 1, 7, 1, 0, 0, 1, 32'hDEAD); idle(L + 1);
        // IMUL then an ALU with rd hitting the reserved slot.
        add(1, FU_IMUL, 1, 8, 2, 0, 0, 1, 32'h1111); idle(3);
        add(1, FU_ALU, 1, 9, 4, 0, 0, 0, 32'h0);
        add(1, FU_ALU, 1, 9, 4, 0, 0, 1, 32'h2222); idle(2);
        // Back-to-back IMULs.
        for (int i = 0; i < 5; i++) add(1, FU_IMUL, 1, 10 + i, 10 + i, 0, 0, 1, 32'hA000 + i);
        idle(L + 1);
        // Branches, taken and not taken.
        add(1, FU_BR, 0, 0, 9, 0, 0, 1, 32'h1);
        add(1, FU_BR, 0, 0, 6, 0, 0, 1, 32'h0); idle(2);
        // ALU without rd completes with zero prd/data.
        add(1, FU_ALU, 0, 33, 25, 0, 0, 1, 32'hFFFF); idle(2);
        // Flush kills an in-flight IMUL and its reservation; issue in flush cycle dropped.
        add(1, FU_IMUL, 1, 15, 15, 0, 0, 1, 32'h5555); idle(1);
        add(1, FU_ALU, 1, 17, 17, 1, 0, 1, 32'h7777); idle(1);
        add(1, FU_ALU, 1, 16, 16, 0, 0, 1, 32'h3333); idle(L);
        // Flush in the completion cycle of ALU and BR ops.
        add(1, FU_ALU, 1, 18, 18, 0, 0, 1, 32'h8888); idle(1, 1'b1);
        add(1, FU_BR, 0, 0, 19, 0, 0, 1, 32'h1); idle(1, 1'b1); idle(2);
        // ALU without rd collides with IMUL writeback and is deferred one cycle.
        add(1, FU_IMUL, 1, 20, 20, 0, 0, 1, 32'hCAFE); idle(3);
        add(1, FU_ALU, 0, 44, 21, 0, 0, 1, 32'h9999); idle(1);
        add(1, FU_ALU, 1, 22, 22, 0, 0, 0, 32'h0);
        add(1, FU_ALU, 1, 22, 22, 0, 0, 1, 32'hBEEF); idle(2);
        // Reset mid-flight discards the IMUL and its reservation.
        add(1, FU_IMUL, 1, 30, 30, 0, 0, 1, 32'h4444); idle(1, 1'b0, 1'b1); idle(2);
        add(1, FU_ALU, 1, 31, 31, 0, 0, 1, 32'h6666); idle(L);

        reset = 1'b1; flush = 1'b0; issue_valid = 1'b0; issue_fu = FU_ALU;
        issue_has_rd = 1'b1; issue_prd = '0; issue_rob = '0;
        alu_out = '0; imul_out = '0; br_out = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst_ready", issue_ready, 1);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_br_valid", br_valid, 0);
        check("rst_wb_data", wb_data, 0);

        for (int i = 0; i < tv.size(); i++) begin
            v = tv[i];
            @(negedge clock);
            reset = v.rst; flush = v.fl; issue_valid = v.vld; issue_fu = v.fu;
            issue_has_rd = v.rd; issue_prd = v.prd; issue_rob = v.rob;
            alu_out  = alu_at.exists(cyc)  ? alu_at[cyc]  : (32'hBAD0_0000 | cyc);
            imul_out = imul_at.exists(cyc) ? imul_at[cyc] : (32'hBAD1_0000 | cyc);
            br_out   = br_at.exists(cyc)   ? br_at[cyc]   : $urandom_range(0, 1);
            if (v.rst || v.fl) begin
                wb_q.delete();
                br_q.delete();
            end
            #1;
            check("issue_ready", issue_ready, v.rdy);
            acc = v.vld && v.rdy && !v.fl;
            exp_fire = 3'b000;
            if (acc) exp_fire = (v.fu == FU_ALU) ? 3'b100 : (v.fu == FU_BR) ? 3'b010 : 3'b001;
            check("fire", {alu_fire, br_fire, imul_fire}, exp_fire);
            if (acc) begin
                e.prd  = v.rd ? v.prd : 6'd0;
                e.rob  = v.rob;
                e.data = v.rd ? v.dat : 32'd0;
                if (v.fu == FU_ALU) begin
                    alu_at[cyc + 1] = v.dat;
                    e.cyc = cyc + 1;
                    while (slot_taken(e.cyc)) e.cyc++;
                    push_wb(e);
                end else if (v.fu == FU_IMUL) begin
                    imul_at[cyc + L] = v.dat;
                    e.cyc = cyc + L;
                    push_wb(e);
                end else begin
                    br_at[cyc + 1] = v.dat[0];
                    b.cyc = cyc + 1; b.rob = v.rob; b.taken = v.dat[0];
                    br_q.push_back(b);
                end
            end
            if (wb_q.size() > 0 && wb_q[0].cyc == cyc) begin
                e = wb_q.pop_front();
                check("wb_valid", wb_valid, 1);
                check("wb_prd", wb_prd, e.prd);
                check("wb_rob", wb_rob, e.rob);
                check("wb_data", wb_data, e.data);
            end else begin
                check("wb_valid_idle", wb_valid, 0);
            end
            if (br_q.size() > 0 && br_q[0].cyc == cyc) begin
                b = br_q.pop_front();
                check("br_valid", br_valid, 1);
                check("br_rob", br_rob, b.rob);
                check("br_taken", br_taken, b.taken);
            end else begin
                check("br_valid_idle", br_valid, 0);
            end
            cyc++;
        end

        check("wb_left", wb_q.size(), 0);
        check("br_left", br_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
